// File: rtl/ulpi_pkg.sv
// Shared definitions for the ULPI register-scan block.
// Holds the ULPI address/data widths, the {addr,data} record width and the
// scan sequencer state encoding.
package ulpi_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int REC_W  = ADDR_W + DATA_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_PUSH      = 3'd4
    } state_t;

endpackage

// File: rtl/ulpi_scan_fifo.sv
// Small synchronous FIFO buffering {addr,data} scan records.
// Ports:
//   clk, rst    clock, synchronous active-high reset (empties the FIFO)
//   push        write push_data when not full (ignored when full)
//   push_data   record to write
//   pop         drop the head when not empty (ignored when empty)
//   full, empty occupancy flags
//   head        oldest record; meaningful only while empty=0
module ulpi_scan_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // Storage is cleared too so the head reads zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ulpi_reg_scan.sv
// ULPI register-scan sequencer. One START reads every PHY register from
// START_ADDR to END_ADDR through the register-read engine and queues
// {addr,data} records for the report path. A stuck transaction aborts the
// scan after TIMEOUT_CYCLES wait cycles.
// Optional build macro: ULPI_SCAN_CONTINUOUS_EN -- rescan immediately after
// END_ADDR while START is still high.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   START        start request, sampled in idle only
//   BUSY         scan in progress
//   DONE         one-cycle pulse at the end of a scan (normal or aborted)
//   TIMEOUT_ERR  sticky abort flag, cleared by rst or an accepted START
//   READ_DATA    one-cycle read request to the engine
//   ADDR         register address presented to the engine
//   RD_DATA      byte returned by the engine
//   RD_BUSY      engine busy flag
//   OUT_DATA     FIFO head {addr, data}
//   OUT_VALID    FIFO not empty
//   OUT_READY    consumer accepts head on OUT_VALID && OUT_READY
module ulpi_reg_scan
    import ulpi_pkg::*;
#(
    parameter logic [5:0] START_ADDR     = 6'h00,
    parameter logic [5:0] END_ADDR       = 6'h03,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              TIMEOUT_ERR,
    output logic              READ_DATA,
    output logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] RD_DATA,
    input  logic              RD_BUSY,
    output logic [REC_W-1:0]  OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);

    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Abort fires on the TIMEOUT_CYCLES-th wait cycle of a transaction.
    localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   addr_q;
    logic [TCNT_W-1:0]   tcnt;
    logic                timeout_err_q;
    logic [REC_W-1:0]    cap;

    logic fifo_full;
    logic fifo_empty;
    logic fifo_push;
    logic last_addr;
    logic load_start;
    logic inc_addr;
    logic capture;
    logic set_err;
    logic clr_err;
    logic done_c;
    logic req_c;
    logic timed_out;

    // A reversed range degenerates to a single read of START_ADDR.
    assign last_addr = (addr_q == END_ADDR) || (START_ADDR > END_ADDR);
    assign timed_out = (tcnt >= TLAST);

    always_comb begin
        state_nx   = state;
        fifo_push  = 1'b0;
        load_start = 1'b0;
        inc_addr   = 1'b0;
        capture    = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        done_c     = 1'b0;
        req_c      = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    clr_err    = 1'b1;
                    load_start = 1'b1;
                    state_nx   = S_REQ;
                end
            end
            S_REQ: begin
                req_c    = 1'b1;
                state_nx = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (RD_BUSY) begin
                    state_nx = S_WAIT_DONE;
                end else if (timed_out) begin
                    set_err  = 1'b1;
                    done_c   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!RD_BUSY) begin
                    capture  = 1'b1;
                    state_nx = S_PUSH;
                end else if (timed_out) begin
                    set_err  = 1'b1;
                    done_c   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_PUSH: begin
                // A full FIFO holds the sequencer here; no new request goes out.
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    if (last_addr) begin
                        done_c   = 1'b1;
`ifdef ULPI_SCAN_CONTINUOUS_EN
                        if (START) begin
                            load_start = 1'b1;
                            state_nx   = S_REQ;
                        end else begin
                            state_nx   = S_IDLE;
                        end
`else
                        state_nx = S_IDLE;
`endif
                    end else begin
                        inc_addr = 1'b1;
                        state_nx = S_REQ;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            addr_q        <= START_ADDR;
            tcnt          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (load_start) begin
                addr_q <= START_ADDR;
            end else if (inc_addr) begin
                addr_q <= addr_q + 1'b1;
            end
            if (state == S_REQ) begin
                tcnt <= '0;
            end else if (state == S_WAIT_BUSY || state == S_WAIT_DONE) begin
                tcnt <= tcnt + 1'b1;
            end
            if (set_err) begin
                timeout_err_q <= 1'b1;
            end else if (clr_err) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            cap <= {addr_q, RD_DATA};
        end
    end

    ulpi_scan_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (cap),
        .pop       (OUT_VALID && OUT_READY),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (OUT_DATA)
    );

    assign BUSY        = (state != S_IDLE);
    assign DONE        = done_c;
    assign TIMEOUT_ERR = timeout_err_q;
    assign READ_DATA   = req_c;
    assign ADDR        = addr_q;
    assign OUT_VALID   = !fifo_empty;

endmodule

// File: tb/tb_ulpi_reg_scan.sv
// Scoreboard bench for ulpi_reg_scan: a register-read engine model answers
// requests, each scan pushes its expected {addr,data} records into a queue,
// and a monitor pops and compares whenever a record is handed off.
module tb_ulpi_reg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        START;
    logic        BUSY;
    logic        DONE;
    logic        TIMEOUT_ERR;
    logic        READ_DATA;
    logic [5:0]  ADDR;
    logic [7:0]  RD_DATA;
    logic        RD_BUSY;
    logic [13:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int req_cnt  = 0;
    int stuck_addr = -1;
    int eng_cnt = 0;

    logic [13:0] exp_q [$];
    logic [7:0]  regs [0:3];

    ulpi_reg_scan #(
        .START_ADDR     (6'h00),
        .END_ADDR       (6'h03),
        .FIFO_DEPTH     (2),
        .TIMEOUT_CYCLES (1023)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .START       (START),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .READ_DATA   (READ_DATA),
        .ADDR        (ADDR),
        .RD_DATA     (RD_DATA),
        .RD_BUSY     (RD_BUSY),
        .OUT_DATA    (OUT_DATA),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
    endtask

    task automatic push_scan(input int first, input int last);
        for (int a = first; a <= last; a++) begin
            exp_q.push_back({6'(a), regs[a]});
        end
    endtask

    task automatic wait_done(input int base, input int limit, output int cycles);
        cycles = 0;
        while (done_cnt == base && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        check("done_within_bound", 32'(done_cnt != base), 1);
    endtask

    // Engine model: busy the cycle after the request, byte returned three
    // cycles later; a stuck address never releases busy.
    initial begin
        RD_BUSY = 1'b0;
        RD_DATA = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                RD_BUSY = 1'b0;
                eng_cnt = 0;
            end else if (RD_BUSY) begin
                if (int'(ADDR) != stuck_addr) begin
                    if (eng_cnt > 1) begin
                        eng_cnt--;
                    end else begin
                        RD_DATA = regs[ADDR[1:0]];
                        RD_BUSY = 1'b0;
                    end
                end
            end else if (READ_DATA) begin
                RD_BUSY = 1'b1;
                eng_cnt = 3;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (DONE) done_cnt++;
                if (READ_DATA) req_cnt++;
                if (OUT_VALID && OUT_READY) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL record_unexpected: got 0x%0h, expected no record", OUT_DATA);
                    end else begin
                        check("record", 32'(OUT_DATA), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rbase;
        int c;
        int passes;

        regs[0] = 8'h24;
        regs[1] = 8'h04;
        regs[2] = 8'h09;
        regs[3] = 8'h00;

        rst = 1'b1;
        START = 1'b0;
        OUT_READY = 1'b1;
        cyc(3);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_read_data", 32'(READ_DATA), 0);
        check("rst_done", 32'(DONE), 0);
        check("rst_timeout_err", 32'(TIMEOUT_ERR), 0);
        check("rst_out_valid", 32'(OUT_VALID), 0);
        check("rst_out_data", 32'(OUT_DATA), 0);
        check("rst_addr", 32'(ADDR), 0);
        rst = 1'b0;
        cyc(2);

        // Plain scan with a free-running consumer
        base = done_cnt; rbase = req_cnt;
        push_scan(0, 3);
        pulse_start();
        check("latency_read_data", 32'(READ_DATA), 1);
        wait_done(base, 200, c);
        cyc(3);
        check("scan_done_count", 32'(done_cnt - base), 1);
        check("scan_req_count", 32'(req_cnt - rbase), 4);
        check("scan_timeout_err", 32'(TIMEOUT_ERR), 0);
        check("scan_busy_after", 32'(BUSY), 0);
        check("scan_queue_empty", 32'(exp_q.size()), 0);

        // Back-pressure: FIFO of two fills and the sequencer stalls
        OUT_READY = 1'b0;
        base = done_cnt; rbase = req_cnt;
        push_scan(0, 3);
        pulse_start();
        cyc(60);
        check("stall_req_count", 32'(req_cnt - rbase), 3);
        check("stall_busy", 32'(BUSY), 1);
        check("stall_out_valid", 32'(OUT_VALID), 1);
        check("stall_read_data", 32'(READ_DATA), 0);
        c = req_cnt;
        cyc(10);
        check("stall_no_new_req", 32'(req_cnt - c), 0);
        check("stall_nothing_popped", 32'(exp_q.size()), 4);
        OUT_READY = 1'b1;
        wait_done(base, 200, c);
        cyc(4);
        check("stall_done_count", 32'(done_cnt - base), 1);
        check("stall_req_total", 32'(req_cnt - rbase), 4);
        check("stall_queue_empty", 32'(exp_q.size()), 0);

        // Timeout: engine hangs at address 2
        OUT_READY = 1'b0;
        stuck_addr = 2;
        base = done_cnt; rbase = req_cnt;
        push_scan(0, 1);
        pulse_start();
        wait_done(base, 1500, c);
        check("timeout_min_wait", 32'(c >= 1023), 1);
        check("timeout_max_wait", 32'(c <= 1100), 1);
        check("timeout_err_set", 32'(TIMEOUT_ERR), 1);
        check("timeout_busy", 32'(BUSY), 0);
        check("timeout_out_valid", 32'(OUT_VALID), 1);
        check("timeout_req_count", 32'(req_cnt - rbase), 3);
        stuck_addr = -1;
        OUT_READY = 1'b1;
        cyc(5);
        check("timeout_drained", 32'(OUT_VALID), 0);
        check("timeout_queue_empty", 32'(exp_q.size()), 0);
        check("timeout_err_sticky", 32'(TIMEOUT_ERR), 1);
        base = done_cnt;
        push_scan(0, 3);
        pulse_start();
        check("timeout_err_cleared", 32'(TIMEOUT_ERR), 0);
        wait_done(base, 200, c);
        cyc(3);
        check("rescan_queue_empty", 32'(exp_q.size()), 0);

        // Reset while waiting on the engine for address 1
        base = done_cnt; rbase = req_cnt;
        push_scan(0, 0);
        pulse_start();
        c = 0;
        while (req_cnt - rbase < 2 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("mid_reset_reached_addr1", 32'(req_cnt - rbase), 2);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        check("mid_reset_busy", 32'(BUSY), 0);
        check("mid_reset_read_data", 32'(READ_DATA), 0);
        check("mid_reset_out_valid", 32'(OUT_VALID), 0);
        check("mid_reset_addr", 32'(ADDR), 0);
        check("mid_reset_no_done", 32'(done_cnt - base), 0);
        rst = 1'b0;
        cyc(3);
        check("mid_reset_queue_empty", 32'(exp_q.size()), 0);

        // START pulses while busy are ignored
        base = done_cnt; rbase = req_cnt;
        push_scan(0, 3);
        pulse_start();
        cyc(3);
        pulse_start();
        cyc(5);
        pulse_start();
        wait_done(base, 200, c);
        cyc(3);
        check("ignore_req_count", 32'(req_cnt - rbase), 4);
        check("ignore_done_count", 32'(done_cnt - base), 1);
        check("ignore_queue_empty", 32'(exp_q.size()), 0);

        // START held high, dropped right after the first DONE
`ifdef ULPI_SCAN_CONTINUOUS_EN
        passes = 2;
`else
        passes = 1;
`endif
        base = done_cnt; rbase = req_cnt;
        for (int p = 0; p < passes; p++) push_scan(0, 3);
        START = 1'b1;
        wait_done(base, 200, c);
        START = 1'b0;
        c = 0;
        while (BUSY && c < 300) begin
            @(negedge clk);
            c++;
        end
        cyc(3);
        check("held_idle", 32'(BUSY), 0);
        check("held_done_count", 32'(done_cnt - base), 32'(passes));
        check("held_req_count", 32'(req_cnt - rbase), 32'(4 * passes));
        check("held_queue_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
